// File: rtl/matrix_scan_driver_pkg.sv
// Shared types for the LED matrix scan path: grid layout, scan states and row extraction.
package matrix_pkg;

  localparam int GRID_DIM = 8;

  // Row r occupies bits [8r+7:8r]; bit c within a row is column c.
  typedef logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;

  typedef enum logic {
    S_BLANK,
    S_DRIVE
  } scan_state_e;

  function automatic logic [GRID_DIM-1:0] grid_row(input grid_t g, input logic [2:0] idx);
    return g[idx];
  endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Frame handoff from the grid-update block: one 64-bit generation per valid/ready transfer.
interface matrix_scan_driver_if;
  import matrix_pkg::*;

  grid_t frame_in;
  logic  frame_valid;
  logic  frame_ready;

  modport master (output frame_in, output frame_valid, input frame_ready);
  modport slave  (input frame_in, input frame_valid, output frame_ready);

endinterface

// File: rtl/matrix_scan_driver_buffer.sv
// Shadow/active frame pair: the shadow takes new generations, the active frame feeds the scanner.
module grid_double_buffer
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 restart_n,
  matrix_scan_driver_if.slave  in_if,
  input  logic                 swap_i,
  output grid_t                active_o,
  output logic [15:0]          frame_count_o
);

  grid_t       shadow_q, shadow_d;
  grid_t       active_q, active_d;
  logic        shadow_full_q, shadow_full_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        accept;

  // Accept needs an empty shadow and swap needs a full one, so the two never collide.
  always_comb begin
    accept        = in_if.frame_valid && !shadow_full_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    active_d      = active_q;
    frame_count_d = frame_count_q;
    if (accept) begin
      shadow_d      = in_if.frame_in;
      shadow_full_d = 1'b1;
    end else if (swap_i && shadow_full_q) begin
      active_d      = shadow_q;
      shadow_full_d = 1'b0;
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!restart_n) begin
      shadow_full_q <= 1'b0;
      active_q      <= '0;
      frame_count_q <= '0;
    end else begin
      shadow_full_q <= shadow_full_d;
      active_q      <= active_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign in_if.frame_ready = !shadow_full_q;
  assign active_o          = active_q;
  assign frame_count_o     = frame_count_q;

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed 8x8 LED scanner with blanking between rows and tear-free frame swaps.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROW_DWELL      = 12500,
  parameter int BLANK_CYCLES   = 100,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                restart_n,
  matrix_scan_driver_if.slave frame_if,
  input  logic                display_en,
  output logic [7:0]          row_sel,
  output logic [7:0]          col_data,
  output logic                frame_start,
  output logic [15:0]         frame_count
);

  localparam int MAX_CYC = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(ROW_DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [7:0] ROW_OFF = {8{ROW_ACTIVE_LOW}};
  localparam logic [7:0] COL_OFF = {8{COL_ACTIVE_LOW}};

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic [7:0]       row_sel_q, row_sel_d;
  logic [7:0]       col_data_q, col_data_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       row_on;
  logic             swap;
  grid_t            active;

  grid_double_buffer u_buf (
    .clk           (clk),
    .restart_n     (restart_n),
    .in_if         (frame_if),
    .swap_i        (swap),
    .active_o      (active),
    .frame_count_o (frame_count)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_idx_d = row_idx_q;
    swap      = 1'b0;
    if (display_en) begin
      case (state_q)
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d   = S_BLANK;
            cnt_d     = '0;
            row_idx_d = row_idx_q + 3'd1;
            swap      = (row_idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_BLANK;
      endcase
    end

    // Outputs are computed from the next state so they line up with the state register.
    row_on = 8'h01 << row_idx_d;
    if (display_en && (state_d == S_DRIVE)) begin
      row_sel_d  = row_on ^ ROW_OFF;
      col_data_d = grid_row(active, row_idx_d) ^ COL_OFF;
    end else begin
      row_sel_d  = ROW_OFF;
      col_data_d = COL_OFF;
    end
    frame_start_d = display_en && (state_q == S_BLANK) && (state_d == S_DRIVE) &&
                    (row_idx_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (!restart_n) begin
      state_q       <= S_BLANK;
      cnt_q         <= '0;
      row_idx_q     <= '0;
      row_sel_q     <= ROW_OFF;
      col_data_q    <= COL_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_idx_q     <= row_idx_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;

endmodule
